// File: rtl/hazard3_ahb_sram_excl.sv
// AHB5 SRAM subordinate: programmable wait states, two-cycle ERROR, optional exclusive monitor.
// Define HAZARD3_AHB_SRAM_EXCL_EN to build the LR/SC reservation monitor.
module hazard3_ahb_sram_excl #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int N_RESV      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [W_ADDR-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [3:0]        hprot,
    input  logic [7:0]        hmaster,
    input  logic              hexcl,
    input  logic              hready,
    input  logic [W_DATA-1:0] hwdata,
    output logic              hready_resp,
    output logic              hresp,
    output logic              hexokay,
    output logic [W_DATA-1:0] hrdata
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] addr_q;
    logic [1:0]    alo_q;
    logic [2:0]    size_q;
    logic [7:0]    master_q;
    logic          write_q, excl_q, err_q;
    logic [2:0]    cnt;

    logic take, acc_err, commit, wr_ok, wr_en, rd_en;
    logic [AW-1:0] rd_addr;
    logic [3:0]    be;

    assign take    = hsel && htrans[1] && hready && (state == S_IDLE || state == S_DATA);
    assign acc_err = (hsize > 3'd2) || (hsize == 3'd1 && haddr[0]) ||
                     (hsize == 3'd2 && |haddr[1:0]) || (|haddr[W_ADDR-1:AW+2]);

    // The second ERROR cycle is DATA with err_q set.
    always_comb begin
        state_nxt   = state;
        hready_resp = 1'b1;
        hresp       = 1'b0;
        case (state)
            S_IDLE, S_DATA: begin
                hresp = (state == S_DATA) && err_q;
                if (take)
                    state_nxt = acc_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);
                else
                    state_nxt = S_IDLE;
            end
            S_WAIT: begin
                hready_resp = 1'b0;
                if (cnt == 3'd0) state_nxt = S_DATA;
            end
            S_ERR1: begin
                hready_resp = 1'b0;
                hresp       = 1'b1;
                state_nxt   = S_DATA;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            alo_q    <= '0;
            size_q   <= '0;
            master_q <= '0;
            write_q  <= 1'b0;
            excl_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                addr_q   <= haddr[AW+1:2];
                alo_q    <= haddr[1:0];
                size_q   <= hsize;
                master_q <= hmaster;
                write_q  <= hwrite;
                excl_q   <= hexcl;
                err_q    <= acc_err;
                cnt      <= (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
            end else if (state == S_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_comb begin
        case (size_q)
            3'd0:    be = 4'b0001 << alo_q;
            3'd1:    be = alo_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign commit = (state == S_DATA) && !err_q;
    assign wr_en  = commit && write_q && wr_ok;

`ifdef HAZARD3_AHB_SRAM_EXCL_EN
    localparam int RW = (N_RESV > 1) ? $clog2(N_RESV) : 1;
    logic [N_RESV-1:0]         resv_vld;
    logic [N_RESV-1:0][AW-1:0] resv_addr;
    logic                      own, excl_hit;
    logic [RW-1:0]             midx;

    assign own      = master_q < 8'(N_RESV);
    assign midx     = master_q[RW-1:0];
    assign excl_hit = own && resv_vld[midx] && (resv_addr[midx] == addr_q);
    assign wr_ok    = !excl_q || excl_hit;
    assign hexokay  = commit && excl_q && (write_q ? excl_hit : own);

    // Any committed write kills matching reservations; a failed SC drops only its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_vld  <= '0;
            resv_addr <= '0;
        end else if (commit) begin
            for (int i = 0; i < N_RESV; i++)
                if (wr_en && resv_addr[i] == addr_q) resv_vld[i] <= 1'b0;
            if (excl_q && own) begin
                if (!write_q) begin
                    resv_vld[midx]  <= 1'b1;
                    resv_addr[midx] <= addr_q;
                end else if (!excl_hit) begin
                    resv_vld[midx] <= 1'b0;
                end
            end
        end
    end
`else
    assign wr_ok   = !excl_q;
    assign hexokay = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{hprot, htrans[0], master_q};

    logic [W_DATA-1:0] mem [DEPTH];

    assign rd_en   = (take && !acc_err && WAIT_STATES == 0) || (state == S_WAIT && cnt == 3'd0);
    assign rd_addr = (state == S_WAIT) ? addr_q : haddr[AW+1:2];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (wr_en && be[b]) mem[addr_q][8*b +: 8] <= hwdata[8*b +: 8];
    end

    // Read issued alongside a write commit to the same word sees the new bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hrdata <= '0;
        else if (rd_en)
            for (int b = 0; b < 4; b++)
                hrdata[8*b +: 8] <= (wr_en && be[b] && addr_q == rd_addr) ?
                                    hwdata[8*b +: 8] : mem[rd_addr][8*b +: 8];
    end
endmodule

// File: tb/tb_hazard3_ahb_sram_excl.sv
// Directed bench: a zero-wait instance and a three-wait-state instance share one AHB bus.
module tb_hazard3_ahb_sram_excl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel0 = 1'b0, hsel1 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [3:0]  hprot = '0;
    logic [7:0]  hmaster = '0;
    logic        hexcl = 1'b0;
    logic [31:0] hwdata = '0;
    logic        hr0, hr1, hresp0, hresp1, hx0, hx1, hready;
    logic [31:0] hrd0, hrd1;
    logic        cur3 = 1'b0;
    int          ncmp = 0, nerr = 0;

`ifdef HAZARD3_AHB_SRAM_EXCL_EN
    localparam logic EXCL = 1'b1;
`else
    localparam logic EXCL = 1'b0;
`endif

    always #5 clk = ~clk;
    assign hready = hr0 & hr1;

    hazard3_ahb_sram_excl #(.WAIT_STATES(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hmaster(hmaster), .hexcl(hexcl),
        .hready(hready), .hwdata(hwdata), .hready_resp(hr0), .hresp(hresp0),
        .hexokay(hx0), .hrdata(hrd0));

    hazard3_ahb_sram_excl #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hmaster(hmaster), .hexcl(hexcl),
        .hready(hready), .hwdata(hwdata), .hready_resp(hr1), .hresp(hresp1),
        .hexokay(hx1), .hrdata(hrd1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One complete transfer; returns data-phase results and the count of stalled cycles.
    task automatic xfer(input logic ws3, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [7:0] m, input logic ex, input logic [31:0] wd,
                        output logic [31:0] rd, output logic r1, output logic r2,
                        output logic ok, output int waits);
        cur3 = ws3; hsel0 = !ws3; hsel1 = ws3;
        htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hmaster = m; hexcl = ex;
        step();
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hexcl = 1'b0; hwdata = wd;
        r1 = ws3 ? hresp1 : hresp0;
        waits = 0;
        while (!hready && waits < 20) begin
            step();
            waits++;
        end
        if (waits >= 20) chk("timeout", 32'(waits), 32'd0);
        rd = ws3 ? hrd1 : hrd0;
        r2 = ws3 ? hresp1 : hresp0;
        ok = ws3 ? hx1 : hx0;
        step();
    endtask

    logic [31:0] rd;
    logic        r1, r2, ok;
    int          w;

    initial begin
        #2;
        chk("rst_hready", {31'd0, hr0}, 32'd1);
        chk("rst_hresp", {31'd0, hresp0}, 32'd0);
        chk("rst_hexokay", {31'd0, hx0}, 32'd0);
        chk("rst_hrdata", hrd0, 32'd0);
        #20 rst_n = 1'b1;
        step();

        // Write then immediate read of the same word: forwarding path
        hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; hmaster = 8'd0;
        step();
        hwrite = 1'b0; hwdata = 32'hDEADBEEF;
        step();
        hsel0 = 1'b0; htrans = 2'b00;
        chk("fwd_hready", {31'd0, hr0}, 32'd1);
        chk("fwd_rdata", hrd0, 32'hDEADBEEF);
        chk("fwd_hresp", {31'd0, hresp0}, 32'd0);
        step();

        // Byte and halfword lanes
        xfer(0, 32'h20, 1, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        xfer(0, 32'h21, 1, 3'd0, 8'd0, 0, 32'h0000AA00, rd, r1, r2, ok, w);
        xfer(0, 32'h22, 1, 3'd1, 8'd0, 0, 32'h12340000, rd, r1, r2, ok, w);
        xfer(0, 32'h20, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("lanes_rdata", rd, 32'h1234AA00);
        chk("lanes_waits", 32'(w), 32'd0);

        // Errors: out of range and misaligned
        xfer(0, 32'h1000, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("oor_waits", 32'(w), 32'd1);
        chk("oor_resp1", {31'd0, r1}, 32'd1);
        chk("oor_resp2", {31'd0, r2}, 32'd1);
        xfer(0, 32'h3, 0, 3'd1, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("mis_waits", 32'(w), 32'd1);
        chk("mis_resp1", {31'd0, r1}, 32'd1);
        chk("mis_resp2", {31'd0, r2}, 32'd1);
        xfer(0, 32'h1010, 1, 3'd2, 8'd0, 0, 32'h0BADF00D, rd, r1, r2, ok, w);
        chk("oorw_resp2", {31'd0, r2}, 32'd1);
        xfer(0, 32'h11, 1, 3'd1, 8'd0, 0, 32'hFFFFFFFF, rd, r1, r2, ok, w);
        xfer(0, 32'h10, 3'd3, 3'd3, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("size3_resp1", {31'd0, r1}, 32'd1);
        xfer(0, 32'h10, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("err_nowrite", rd, 32'hDEADBEEF);
        chk("ok_resp", {31'd0, r2}, 32'd0);

        // Three wait states
        xfer(1, 32'h8, 1, 3'd2, 8'd0, 0, 32'h11223344, rd, r1, r2, ok, w);
        chk("ws3_wr_waits", 32'(w), 32'd3);
        xfer(1, 32'h8, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("ws3_rd_waits", 32'(w), 32'd3);
        chk("ws3_rd_first", {31'd0, r1}, 32'd0);
        chk("ws3_rdata", rd, 32'h11223344);

        // LR/SC by master 0
        xfer(0, 32'h40, 1, 3'd2, 8'd0, 0, 32'h77, rd, r1, r2, ok, w);
        xfer(0, 32'h40, 0, 3'd2, 8'd0, 1, 32'h0, rd, r1, r2, ok, w);
        chk("lr_rdata", rd, 32'h77);
        chk("lr_exokay", {31'd0, ok}, {31'd0, EXCL});
        xfer(0, 32'h40, 1, 3'd2, 8'd0, 1, 32'h5, rd, r1, r2, ok, w);
        chk("sc_exokay", {31'd0, ok}, {31'd0, EXCL});
        chk("sc_hresp", {31'd0, r2}, 32'd0);
        xfer(0, 32'h40, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("sc_mem", rd, EXCL ? 32'h5 : 32'h77);

        // Reservation killed by another master's plain write
        xfer(0, 32'h40, 0, 3'd2, 8'd0, 1, 32'h0, rd, r1, r2, ok, w);
        xfer(0, 32'h40, 1, 3'd2, 8'd1, 0, 32'h99, rd, r1, r2, ok, w);
        xfer(0, 32'h40, 1, 3'd2, 8'd0, 1, 32'hAB, rd, r1, r2, ok, w);
        chk("scx_exokay", {31'd0, ok}, 32'd0);
        chk("scx_hresp", {31'd0, r2}, 32'd0);
        xfer(0, 32'h40, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("scx_mem", rd, 32'h99);

        // SBA master has no reservation entry
        xfer(0, 32'h40, 0, 3'd2, 8'h10, 1, 32'h0, rd, r1, r2, ok, w);
        chk("sba_lr_rdata", rd, 32'h99);
        chk("sba_lr_exokay", {31'd0, ok}, 32'd0);
        xfer(0, 32'h40, 1, 3'd2, 8'h10, 1, 32'h1, rd, r1, r2, ok, w);
        chk("sba_sc_exokay", {31'd0, ok}, 32'd0);
        xfer(0, 32'h40, 0, 3'd2, 8'd0, 0, 32'h0, rd, r1, r2, ok, w);
        chk("sba_sc_mem", rd, 32'h99);

        // Master 1 LR/SC, then a repeat SC must fail
        xfer(0, 32'h40, 0, 3'd2, 8'd1, 1, 32'h0, rd, r1, r2, ok, w);
        xfer(0, 32'h40, 1, 3'd2, 8'd1, 1, 32'h66, rd, r1, r2, ok, w);
        chk("m1_sc_exokay", {31'd0, ok}, {31'd0, EXCL});
        xfer(0, 32'h40, 1, 3'd2, 8'd1, 1, 32'h55, rd, r1, r2, ok, w);
        chk("m1_sc2_exokay", {31'd0, ok}, 32'd0);
        xfer(0, 32'h40, 0, 3'd2, 8'd1, 0, 32'h0, rd, r1, r2, ok, w);
        chk("m1_sc_mem", rd, EXCL ? 32'h66 : 32'h99);

        // Non-transfers keep a zero-wait OKAY
        hsel0 = 1'b1; htrans = 2'b01; haddr = 32'h1000;
        step();
        chk("busy_hready", {31'd0, hr0}, 32'd1);
        chk("busy_hresp", {31'd0, hresp0}, 32'd0);
        hsel0 = 1'b0; htrans = 2'b00;
        step();
        chk("idle_hexokay", {31'd0, hx0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
